mult_seq_ctrl: RTL and testbench

Sequential shift-and-add unsigned multiplier controller with a handshake on both sides.
It reuses one WIDTH+1-bit adder over WIDTH cycles instead of the WIDTH-row full-adder array.
It sits between an operand producer and a result consumer, for area-constrained paths where the combinational array multiplier is too large.
Operands go in with a valid/ready handshake; the 2*WIDTH-bit product comes out with a valid/ready handshake.

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_seq_ctrl_if.sv | 25 ++
 rtl/mult_seq_dp.sv | 78 +++++++
 rtl/mult_seq_ctrl.sv | 109 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // The down-counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand/product handshake bundle for mult_seq_ctrl.
interface mult_seq_ctrl_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     P;
    logic                   busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, P, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, P, busy
    );
endinterface

// File: rtl/mult_seq_dp.sv
// Multiplier datapath: multiplicand/multiplier registers, accumulator, WIDTH+1-bit adder.
// Build option MULT_SEQ_EARLY_TERM_EN adds the zero-detect and multi-bit final shift.
module mult_seq_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(DEFAULT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 finish,
`ifdef MULT_SEQ_EARLY_TERM_EN
    input  logic                 early,
    input  logic [CNT_W-1:0]     shift_amt,
    output logic                 mreg_zero,
`endif
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mreg_reg;
    logic [PW-1:0]    acc_reg;
    logic [PW-1:0]    p_reg;
    logic [WIDTH:0]   sum;
    logic [PW:0]      wide;
    logic [PW-1:0]    acc_next;

    // The adder keeps its carry as the top bit of the shifted accumulator.
    always_comb begin
        if (mreg_reg[0]) begin
            sum = {1'b0, acc_reg[PW-1:WIDTH]} + {1'b0, mcand_reg};
        end else begin
            sum = {1'b0, acc_reg[PW-1:WIDTH]};
        end
        wide     = {sum, acc_reg[WIDTH-1:0]};
        acc_next = wide[PW:1];
`ifdef MULT_SEQ_EARLY_TERM_EN
        // No partial products remain, so the outstanding shifts collapse into one.
        if (early) begin
            acc_next = PW'(wide >> shift_amt);
        end
`endif
    end

`ifdef MULT_SEQ_EARLY_TERM_EN
    assign mreg_zero = (mreg_reg[WIDTH-1:1] == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg <= '0;
            mreg_reg  <= '0;
            acc_reg   <= '0;
            p_reg     <= '0;
        end else begin
            if (load) begin
                mcand_reg <= b;
                mreg_reg  <= a;
                acc_reg   <= '0;
            end else if (step) begin
                acc_reg   <= acc_next;
                mreg_reg  <= mreg_reg >> 1;
            end
            // P is a separate register so it holds through IDLE and RUN.
            if (finish) begin
                p_reg <= acc_next;
            end
        end
    end

    assign p = p_reg;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier controller: FSM, cycle counter and both handshakes.
// Build option MULT_SEQ_EARLY_TERM_EN finishes as soon as the multiplier runs out of set bits.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_seq_ctrl_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             out_valid_reg, out_valid_next;
    logic             load, step, finish;
    logic [2*WIDTH-1:0] p;
`ifdef MULT_SEQ_EARLY_TERM_EN
    logic             early;
    logic             mreg_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg;
        load           = 1'b0;
        step           = 1'b0;
        finish         = 1'b0;
`ifdef MULT_SEQ_EARLY_TERM_EN
        early          = 1'b0;
`endif
        unique case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    load       = 1'b1;
                    cnt_next   = CNT_W'(WIDTH);
                    state_next = RUN;
                end
            end
            RUN: begin
                step     = 1'b1;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    finish         = 1'b1;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
`ifdef MULT_SEQ_EARLY_TERM_EN
                else if (mreg_zero && (cnt_reg > CNT_W'(1))) begin
                    early          = 1'b1;
                    finish         = 1'b1;
                    cnt_next       = '0;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg == RUN);
    assign bus.out_valid = out_valid_reg;
    assign bus.P         = p;

    mult_seq_dp #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .finish    (finish),
`ifdef MULT_SEQ_EARLY_TERM_EN
        .early     (early),
        .shift_amt (cnt_reg),
        .mreg_zero (mreg_zero),
`endif
        .a         (bus.A),
        .b         (bus.B),
        .p         (p)
    );

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: cycle-level behavioural model plus product scoreboard.
// Honours MULT_SEQ_EARLY_TERM_EN for the expected latency.
module tb_mult_seq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.WIDTH(4)) bus ();
    mult_seq_ctrl #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    mult_seq_ctrl_if #(.WIDTH(8)) bus8 ();
    mult_seq_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int checks  = 0;
    int errors  = 0;
    int results = 0;
    int exp_q[$];
    bit run_cmp  = 1'b0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycles from acceptance to out_valid.
    function automatic int lat_of(input int w, input int a);
`ifdef MULT_SEQ_EARLY_TERM_EN
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i]) return i + 1;
        end
        return 1;
`else
        return w + (a & 0);
`endif
    endfunction

    // Behavioural model: remaining run cycles, a pending result, and the last product shown.
    int m_left;
    bit m_has;
    int m_prod;
    int m_p;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_has  <= 1'b0;
            m_prod <= 0;
            m_p    <= 0;
        end else if (m_has) begin
            if (bus.out_ready) m_has <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_has <= 1'b1;
                m_p   <= m_prod;
            end
        end else if (bus.in_valid) begin
            m_prod <= int'(bus.A) * int'(bus.B);
            m_left <= lat_of(4, int'(bus.A));
        end
    end

    // Compare every cycle on the falling edge; scoreboard pops on each output handshake.
    always @(negedge clk) begin
        if (rst_n && run_cmp) begin
            chk("in_ready", int'(bus.in_ready), int'(!m_has && m_left == 0));
            chk("busy", int'(bus.busy), int'(m_left > 0));
            chk("out_valid", int'(bus.out_valid), int'(m_has));
            chk("P", int'(bus.P), m_p);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got product %0d expected no result", int'(bus.P));
                end else begin
                    chk("sb_product", int'(bus.P), exp_q.pop_front());
                    results++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b);
        bit ok = 1'b0;
        bus.A = 4'(a);
        bus.B = 4'(b);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("accept_timeout", int'(ok), 1);
        if (ok) exp_q.push_back(a * b);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("out_valid_timeout", int'(bus.out_valid), 1);
    endtask

    task automatic run_w8();
        int pa[5] = '{255, 200, 1, 128, 0};
        int pb[5] = '{255, 123, 77, 2, 99};
        int lat;
        bit ok;
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ok = 1'b0;
            bus8.A = 8'(pa[k]);
            bus8.B = 8'(pb[k]);
            bus8.in_valid = 1'b1;
            for (int i = 0; i < 50; i++) begin
                if (bus8.in_ready) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            chk("w8_accept", int'(ok), 1);
            tick();
            bus8.in_valid = 1'b0;
            lat = 0;
            while (!bus8.out_valid && lat < 50) begin
                tick();
                lat++;
            end
            chk("w8_latency", lat, lat_of(8, pa[k]));
            chk("w8_P", int'(bus8.P), pa[k] * pb[k]);
            tick();
        end
    endtask

    initial begin
        int lat;
        bus.in_valid   = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.out_ready  = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.A         = '0;
        bus8.B         = '0;
        bus8.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_P", int'(bus.P), 0);
        rst_n = 1'b1;
        run_cmp = 1'b1;
        tick();

        // 3*5 with latency and ready timing
        bus.out_ready = 1'b1;
        send(3, 5);
        chk("in_ready_low_after_accept", int'(bus.in_ready), 0);
        wait_out(lat);
        chk("latency_3x5", lat, lat_of(4, 3));
        chk("P_3x5", int'(bus.P), 15);
        chk("no_bypass", int'(bus.in_ready), 0);
        tick();
        chk("out_valid_dropped", int'(bus.out_valid), 0);
        chk("in_ready_back", int'(bus.in_ready), 1);

        // Carry path and zero operand
        send(15, 15);
        wait_out(lat);
        chk("P_15x15", int'(bus.P), 225);
        tick();
        send(0, 15);
        wait_out(lat);
        chk("latency_0x15", lat, lat_of(4, 0));
        chk("P_0x15", int'(bus.P), 0);
        tick();

        // Backpressure in DONE with stray in_valid pulses
        bus.out_ready = 1'b0;
        send(11, 13);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.A = 4'($urandom);
            bus.B = 4'($urandom);
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_P", int'(bus.P), 143);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release", int'(bus.out_valid), 0);

        // Operands wiggling during RUN
        send(9, 6);
        for (int i = 0; i < 2; i++) begin
            bus.A = 4'($urandom);
            bus.B = 4'($urandom);
            tick();
        end
        wait_out(lat);
        chk("P_9x6_stable_operands", int'(bus.P), 54);
        tick();

        // Reset in the middle of RUN
        send(12, 10);
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_P", int'(bus.P), 0);
        exp_q.delete();
        results = 0;
        tick();
        rst_n = 1'b1;
        tick();
        send(7, 9);
        wait_out(lat);
        chk("P_7x9", int'(bus.P), 63);
        tick();

        // Exhaustive back-to-back with random out_ready
        rand_rdy = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                send(a, b);
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        tick();
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("result_count", results, 257);

        run_w8();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
